// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - UART frame format encodings and config bundle shared by rx and tx
package uart_rx_pkg;

    localparam int CLK_DIV_W = 20;
    localparam int DATA_W    = 9;

    typedef enum logic [1:0] {
        DATA_7  = 2'd0,
        DATA_8  = 2'd1,
        DATA_9  = 2'd2,
        DATA_8B = 2'd3
    } data_type_e;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_type_e;

    typedef enum logic [1:0] {
        PAR_NONE   = 2'd0,
        PAR_EVEN   = 2'd1,
        PAR_ODD    = 2'd2,
        PAR_EVEN_B = 2'd3
    } parity_type_e;

    typedef struct packed {
        data_type_e           data_type;
        stop_type_e           stop_type;
        parity_type_e         parity_type;
        logic [CLK_DIV_W-1:0] clock_divider;
    } uart_config_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic logic [3:0] data_bits(data_type_e t);
        case (t)
            DATA_7:  return 4'd7;
            DATA_9:  return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx metastability synchroniser with falling-edge detect
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Reset to 1 so an idle line never looks like a start edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rx};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rx_sync = chain[SYNC_STAGES-1];
    assign rx_fall = prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity/stop checks and valid/ready output
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_config_dataType,
    input  logic        io_config_stopType,
    input  logic [1:0]  io_config_parityType,
    input  logic [19:0] io_config_clockDivider,
    input  logic        io_rx,
    output logic        io_data_valid,
    input  logic        io_data_ready,
    output logic [8:0]  io_data_bits,
    output logic        io_data_parityErr,
    output logic        io_data_frameErr,
    output logic        io_overrun
);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (io_rx),
        .rx_sync (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e              state, state_nx;
    uart_config_t           cfg, cfg_nx;
    logic [CLK_DIV_W-1:0]   cnt, cnt_nx;
    logic [3:0]             bit_idx, bit_idx_nx;
    logic [DATA_W-1:0]      shift, shift_nx;
    logic                   acc, acc_nx;
    logic                   perr, perr_nx;
    logic                   ferr, ferr_nx;
    logic                   stop_idx, stop_idx_nx;
    logic                   deliver;
    logic                   tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cfg      <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            acc      <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_nx;
            cfg      <= cfg_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            shift    <= shift_nx;
            acc      <= acc_nx;
            perr     <= perr_nx;
            ferr     <= ferr_nx;
            stop_idx <= stop_idx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cfg_nx      = cfg;
        cnt_nx      = tick ? cnt : cnt - 1'b1;
        bit_idx_nx  = bit_idx;
        shift_nx    = shift;
        acc_nx      = acc;
        perr_nx     = perr;
        ferr_nx     = ferr;
        stop_idx_nx = stop_idx;
        deliver     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    cfg_nx.data_type     = data_type_e'(io_config_dataType);
                    cfg_nx.stop_type     = stop_type_e'(io_config_stopType);
                    cfg_nx.parity_type   = parity_type_e'(io_config_parityType);
                    cfg_nx.clock_divider = io_config_clockDivider;
                    cnt_nx               = io_config_clockDivider >> 1;
                    state_nx             = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx     = cfg.clock_divider;
                        bit_idx_nx = '0;
                        shift_nx   = '0;
                        acc_nx     = (cfg.parity_type == PAR_ODD);
                        perr_nx    = 1'b0;
                        ferr_nx    = 1'b0;
                        state_nx   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_nx[bit_idx] = rx_s;
                    acc_nx            = acc ^ rx_s;
                    cnt_nx            = cfg.clock_divider;
                    bit_idx_nx        = bit_idx + 4'd1;
                    if (bit_idx == data_bits(cfg.data_type) - 4'd1) begin
                        stop_idx_nx = 1'b0;
                        state_nx    = (cfg.parity_type != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    perr_nx     = (rx_s != acc);
                    cnt_nx      = cfg.clock_divider;
                    stop_idx_nx = 1'b0;
                    state_nx    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    ferr_nx = ferr | ~rx_s;
                    // Deliver at the centre of the last stop bit to leave half a bit for resync.
                    if (stop_idx == logic'(cfg.stop_type)) begin
                        deliver  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        stop_idx_nx = 1'b1;
                        cnt_nx      = cfg.clock_divider;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_data_valid     <= 1'b0;
            io_data_bits      <= '0;
            io_data_parityErr <= 1'b0;
            io_data_frameErr  <= 1'b0;
            io_overrun        <= 1'b0;
        end else begin
            io_overrun <= 1'b0;
            if (deliver) begin
                if (!io_data_valid || io_data_ready) begin
                    io_data_valid     <= 1'b1;
                    io_data_bits      <= shift;
                    io_data_parityErr <= perr;
                    io_data_frameErr  <= ferr_nx;
                end else begin
                    io_overrun <= 1'b1;
                end
            end else if (io_data_valid && io_data_ready) begin
                io_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level expected-word model
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  io_config_dataType;
    logic        io_config_stopType;
    logic [1:0]  io_config_parityType;
    logic [19:0] io_config_clockDivider;
    logic        io_rx;
    logic        io_data_valid;
    logic        io_data_ready;
    logic [8:0]  io_data_bits;
    logic        io_data_parityErr;
    logic        io_data_frameErr;
    logic        io_overrun;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .io_config_dataType     (io_config_dataType),
        .io_config_stopType     (io_config_stopType),
        .io_config_parityType   (io_config_parityType),
        .io_config_clockDivider (io_config_clockDivider),
        .io_rx                  (io_rx),
        .io_data_valid          (io_data_valid),
        .io_data_ready          (io_data_ready),
        .io_data_bits           (io_data_bits),
        .io_data_parityErr      (io_data_parityErr),
        .io_data_frameErr       (io_data_frameErr),
        .io_overrun             (io_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] bits;
        logic       perr;
        logic       ferr;
    } word_t;

    word_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         bit_period = 10;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    int         ovr_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [8:0] last_bits = '0;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every presented word must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (io_data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(io_data_bits), 32'h1ff_dead);
                end else begin
                    chk("word_bits", 32'(io_data_bits), 32'(exp_q[0].bits));
                    chk("word_perr", 32'(io_data_parityErr), 32'(exp_q[0].perr));
                    chk("word_ferr", 32'(io_data_frameErr), 32'(exp_q[0].ferr));
                    if (io_data_ready) void'(exp_q.pop_front());
                end
                if (!prev_valid) rise_cyc = cyc;
                last_bits = io_data_bits;
                last_perr = io_data_parityErr;
                last_ferr = io_data_frameErr;
            end
            if (io_overrun) ovr_cnt++;
            prev_valid = io_data_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int dtype, input int stype, input int ptype, input int div);
        io_config_dataType     = 2'(dtype);
        io_config_stopType     = 1'(stype);
        io_config_parityType   = 2'(ptype);
        io_config_clockDivider = 20'(div);
        bit_period             = div + 1;
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input int ptype,
                              input int nstop, input bit pflip, input bit stop_low, input bit push);
        logic [8:0] m;
        logic       pbit;
        word_t      w;
        m = '0;
        for (int i = 0; i < nbits; i++) m[i] = data[i];
        pbit = (ptype == 2) ? ~(^m) : ^m;
        if (pflip) pbit = ~pbit;
        if (push) begin
            w.bits = m;
            w.perr = pflip && (ptype != 0);
            w.ferr = stop_low;
            exp_q.push_back(w);
        end
        start_cyc = cyc;
        io_rx = 1'b0;
        step(bit_period);
        for (int i = 0; i < nbits; i++) begin
            io_rx = m[i];
            step(bit_period);
        end
        if (ptype != 0) begin
            io_rx = pbit;
            step(bit_period);
        end
        for (int s = 0; s < nstop; s++) begin
            io_rx = ~stop_low;
            step(bit_period);
        end
        io_rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 4 * bit_period + 20) begin
            step(1);
            t++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        step(bit_period);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(io_data_valid), 32'd0);
        chk({tag, "_bits"}, 32'(io_data_bits), 32'd0);
        chk({tag, "_perr"}, 32'(io_data_parityErr), 32'd0);
        chk({tag, "_ferr"}, 32'(io_data_frameErr), 32'd0);
        chk({tag, "_overrun"}, 32'(io_overrun), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        io_rx = 1'b1;
        io_data_ready = 1'b1;
        set_cfg(1, 0, 0, 9);
        step(3);
        chk_outputs_zero("reset");
        reset = 1'b0;
        step(10);

        // 8N1 0xA5, with edge-to-valid latency of about ten bit periods
        send_frame(9'h0A5, 8, 0, 1, 1'b0, 1'b0, 1'b1);
        drain("drain_a5");
        chk("a5_bits", 32'(last_bits), 32'h0A5);
        chk("a5_ferr", 32'(last_ferr), 32'd0);
        chk("a5_latency_lo", 32'(rise_cyc - start_cyc >= 96), 32'd1);
        chk("a5_latency_hi", 32'(rise_cyc - start_cyc <= 104), 32'd1);

        // 9-bit odd parity, 2 stop bits
        set_cfg(2, 1, 2, 9);
        send_frame(9'h1FF, 9, 2, 2, 1'b0, 1'b0, 1'b1);
        drain("drain_1ff_ok");
        chk("1ff_bits", 32'(last_bits), 32'h1FF);
        chk("1ff_perr0", 32'(last_perr), 32'd0);
        send_frame(9'h1FF, 9, 2, 2, 1'b1, 1'b0, 1'b1);
        drain("drain_1ff_bad");
        chk("1ff_perr1", 32'(last_perr), 32'd1);

        // 7-bit even parity with a low stop bit, then a clean frame
        set_cfg(0, 0, 1, 9);
        send_frame(9'h055, 7, 1, 1, 1'b0, 1'b1, 1'b1);
        drain("drain_55");
        chk("55_bits", 32'(last_bits), 32'h055);
        chk("55_ferr", 32'(last_ferr), 32'd1);
        send_frame(9'h02A, 7, 1, 1, 1'b0, 1'b0, 1'b1);
        drain("drain_2a");
        chk("2a_bits", 32'(last_bits), 32'h02A);
        chk("2a_ferr", 32'(last_ferr), 32'd0);

        // Alternate encodings for 8 bits and even parity at a different divider
        set_cfg(3, 0, 3, 5);
        send_frame(9'h096, 8, 3, 1, 1'b0, 1'b0, 1'b1);
        drain("drain_96");
        chk("96_bits", 32'(last_bits), 32'h096);

        // Short glitch must be rejected
        set_cfg(1, 0, 0, 9);
        io_rx = 1'b0;
        step(3);
        io_rx = 1'b1;
        step(40);
        chk("glitch_valid", 32'(io_data_valid), 32'd0);
        send_frame(9'h0C3, 8, 0, 1, 1'b0, 1'b0, 1'b1);
        drain("drain_c3");
        chk("c3_bits", 32'(last_bits), 32'h0C3);

        // Backpressure: second back-to-back word is dropped with one overrun pulse
        set_cfg(1, 0, 0, 3);
        io_data_ready = 1'b0;
        ovr_cnt = 0;
        send_frame(9'h011, 8, 0, 1, 1'b0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 0, 1, 1'b0, 1'b0, 1'b0);
        step(20);
        chk("ovr_held_bits", 32'(io_data_bits), 32'h011);
        chk("ovr_held_valid", 32'(io_data_valid), 32'd1);
        chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
        io_data_ready = 1'b1;
        step(2);
        chk("ovr_valid_drop", 32'(io_data_valid), 32'd0);
        chk("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
        step(30);
        chk("ovr_pulses_final", 32'(ovr_cnt), 32'd1);

        // Reset in the middle of the data bits, then a clean frame
        set_cfg(1, 0, 0, 9);
        io_rx = 1'b0;
        step(10);
        io_rx = 1'b0;
        step(10);
        io_rx = 1'b1;
        step(10);
        io_rx = 1'b0;
        step(5);
        reset = 1'b1;
        step(1);
        chk_outputs_zero("midreset");
        io_rx = 1'b1;
        step(3);
        reset = 1'b0;
        step(20);
        chk("post_reset_idle", 32'(io_data_valid), 32'd0);
        send_frame(9'h03C, 8, 0, 1, 1'b0, 1'b0, 1'b1);
        drain("drain_3c");
        chk("3c_bits", 32'(last_bits), 32'h03C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
